// File: rtl/mkio_bus_controller.sv
// mkio_bus_controller
//   Initiator side of an MKIO (MIL-STD-1553) channel. On a host start it sends
//   a command word through the Manchester transmitter. For BC->RT it then sends
//   data words from the buffer and collects the status word. For RT->BC it
//   collects the status word and stores the data words it receives.
// Ports
//   clk, reset (async, active low)
//   host   : start, rt_addr, tr, subaddr, word_cnt, buf_we/buf_addr/buf_wdata,
//            buf_rdata, busy, done, status, err, rx_count
//   tx side: tx_ready, tx_data, tx_cd (out), tx_busy (in)
//   rx side: rx_done, rx_data, rx_cd, p_error (in)
module mkio_bus_controller #(
  parameter logic [15:0] TIMEOUT = 16'd1400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  rt_addr,
  input  logic        tr,
  input  logic [4:0]  subaddr,
  input  logic [4:0]  word_cnt,
  input  logic        buf_we,
  input  logic [4:0]  buf_addr,
  input  logic [15:0] buf_wdata,
  output logic [15:0] buf_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] status,
  output logic [3:0]  err,
  output logic [5:0]  rx_count,
  output logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error
);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, SEND_DATA, WAIT_TX, WAIT_STATUS, RX_DATA, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  rt_addr_q, rt_addr_d;
  logic        tr_q, tr_d;
  logic [4:0]  subaddr_q, subaddr_d;
  logic [4:0]  word_cnt_q, word_cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic        tx_ready_q, tx_ready_d;
  logic        ready_dly_q;
  logic [15:0] tx_data_q, tx_data_d;
  logic        tx_cd_q, tx_cd_d;
  logic [15:0] status_q, status_d;
  logic [3:0]  err_q, err_d;
  logic [5:0]  rx_count_q, rx_count_d;
  logic [15:0] buf_rdata_q;
  logic [15:0] mem_q [32];
  logic        ctl_we;

  logic [5:0]  n_words;
  logic        bcast;
  logic        tx_ok;
  logic        addr_mis;

  assign n_words  = (word_cnt_q == 5'd0) ? 6'd32 : {1'b0, word_cnt_q};
  assign bcast    = (rt_addr_q == 5'd31);
  assign addr_mis = (rx_data[15:11] != rt_addr_q);
  // tx_busy is not trusted during the strobe cycle and the one after it,
  // because the transmitter only raises it after seeing tx_ready.
  assign tx_ok    = !tx_ready_q && !ready_dly_q && !tx_busy;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rt_addr_q   <= '0;
      tr_q        <= 1'b0;
      subaddr_q   <= '0;
      word_cnt_q  <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      tx_ready_q  <= 1'b0;
      ready_dly_q <= 1'b0;
      tx_data_q   <= '0;
      tx_cd_q     <= 1'b0;
      status_q    <= '0;
      err_q       <= '0;
      rx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rt_addr_q   <= rt_addr_d;
      tr_q        <= tr_d;
      subaddr_q   <= subaddr_d;
      word_cnt_q  <= word_cnt_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      tx_ready_q  <= tx_ready_d;
      ready_dly_q <= tx_ready_q;
      tx_data_q   <= tx_data_d;
      tx_cd_q     <= tx_cd_d;
      status_q    <= status_d;
      err_q       <= err_d;
      rx_count_q  <= rx_count_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state_q;
    rt_addr_d  = rt_addr_q;
    tr_d       = tr_q;
    subaddr_d  = subaddr_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    tx_ready_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_cd_d    = tx_cd_q;
    status_d   = status_q;
    err_d      = err_q;
    rx_count_d = rx_count_q;
    ctl_we     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          rt_addr_d  = rt_addr;
          tr_d       = tr;
          subaddr_d  = subaddr;
          word_cnt_d = word_cnt;
          err_d      = '0;
          rx_count_d = '0;
          timer_d    = '0;
          state_d    = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (bcast && tr_q) begin
          // Broadcast transmit has no single responder: abort without sending.
          err_d[0] = 1'b1;
          state_d  = DONE;
        end else if (tx_ok) begin
          tx_ready_d = 1'b1;
          tx_data_d  = {rt_addr_q, tr_q, subaddr_q, word_cnt_q};
          tx_cd_d    = 1'b0;
          idx_d      = '0;
          state_d    = tr_q ? WAIT_TX : SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (tx_ok) begin
          tx_ready_d = 1'b1;
          tx_data_d  = mem_q[idx_q[4:0]];
          tx_cd_d    = 1'b1;
          idx_d      = idx_q + 6'd1;
          if (idx_q + 6'd1 == n_words) state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_ok) begin
          if (bcast) begin
            state_d = DONE;
          end else begin
            // The cycle the line goes quiet counts as the first timer cycle.
            timer_d = 16'd1;
            state_d = WAIT_STATUS;
          end
        end
      end
      WAIT_STATUS: begin
        if (rx_done) begin
          status_d = rx_data;
          err_d    = err_q | {rx_cd, addr_mis, p_error, 1'b0};
          if (rx_cd || addr_mis || p_error) begin
            state_d = DONE;
          end else if (tr_q) begin
            timer_d = '0;
            state_d = RX_DATA;
          end else begin
            state_d = DONE;
          end
        end else if (timer_q == TIMEOUT) begin
          err_d[0] = 1'b1;
          state_d  = DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_done) begin
          if (p_error || !rx_cd) begin
            err_d[1] = err_q[1] | p_error;
            err_d[3] = err_q[3] | !rx_cd;
            state_d  = DONE;
          end else begin
            ctl_we     = 1'b1;
            rx_count_d = rx_count_q + 6'd1;
            timer_d    = '0;
            if (rx_count_q + 6'd1 == n_words) state_d = DONE;
          end
        end else if (timer_q == TIMEOUT) begin
          err_d[0] = 1'b1;
          state_d  = DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE) && (state_q != DONE);
    done = (state_q == DONE);
  end

  // Data buffer: controller write has priority; host writes only when idle
  always_ff @(posedge clk) begin
    if (ctl_we) begin
      mem_q[rx_count_q[4:0]] <= rx_data;
    end else if (buf_we && !busy) begin
      mem_q[buf_addr] <= buf_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) buf_rdata_q <= '0;
    else        buf_rdata_q <= mem_q[buf_addr];
  end

  assign buf_rdata = buf_rdata_q;
  assign status    = status_q;
  assign err       = err_q;
  assign rx_count  = rx_count_q;
  assign tx_ready  = tx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_cd     = tx_cd_q;

endmodule

// File: tb/tb_mkio_bus_controller.sv
// Directed bench for mkio_bus_controller with a simple transmitter responder.
module tb_mkio_bus_controller;
  localparam int TIMEOUT = 1400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rt_addr = '0;
  logic        tr = 1'b0;
  logic [4:0]  subaddr = '0;
  logic [4:0]  word_cnt = '0;
  logic        buf_we = 1'b0;
  logic [4:0]  buf_addr = '0;
  logic [15:0] buf_wdata = '0;
  logic [15:0] buf_rdata;
  logic        busy, done;
  logic [15:0] status;
  logic [3:0]  err;
  logic [5:0]  rx_count;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_busy = 1'b0;
  logic        rx_done = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_cd = 1'b0;
  logic        p_error = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int done_cyc = 0;
  int tx_cnt = 0;
  logic [16:0] txq [$];

  mkio_bus_controller #(.TIMEOUT(16'd1400)) dut (
    .clk(clk), .reset(reset), .start(start), .rt_addr(rt_addr), .tr(tr),
    .subaddr(subaddr), .word_cnt(word_cnt), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .busy(busy), .done(done), .status(status), .err(err),
    .rx_count(rx_count), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_cd(tx_cd), .tx_busy(tx_busy), .rx_done(rx_done), .rx_data(rx_data),
    .rx_cd(rx_cd), .p_error(p_error)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for 4 cycles after each strobe; logs {cd, data}
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_ready) begin
      tx_busy <= 1'b1;
      tx_cnt  <= 4;
      txq.push_back({tx_cd, tx_data});
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) begin
        tx_busy  <= 1'b0;
        fall_cyc <= cyc + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic buf_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    buf_we = 1'b1; buf_addr = a; buf_wdata = d;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic read_buf(input logic [4:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    buf_addr = a;
    @(negedge clk);
    chk(tag, buf_rdata, exp);
  endtask

  task automatic start_txn(input logic [4:0] a, input logic t, input logic [4:0] sa,
                           input logic [4:0] wc);
    @(negedge clk);
    rt_addr = a; tr = t; subaddr = sa; word_cnt = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (!(txq.size() == n && !tx_busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (txq.size() == n && !tx_busy), 1);
  endtask

  task automatic send_rx(input logic [15:0] d, input logic cd, input logic pe);
    @(negedge clk);
    rx_data = d; rx_cd = cd; p_error = pe; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; p_error = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc;
    chk(tag, done, 1);
  endtask

  initial begin
    int seen;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_err", err, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_buf_rdata", buf_rdata, 0);
    reset = 1'b1;

    // BC->RT, two words
    buf_write(5'd0, 16'hA5A5);
    buf_write(5'd1, 16'h1234);
    txq.delete();
    start_txn(5'd1, 1'b0, 5'd5, 5'd2);
    chk("t1_busy", busy, 1);
    wait_tx(3, "t1_txcount");
    repeat (2) @(negedge clk);
    send_rx(16'h0800, 1'b0, 1'b0);
    wait_done(50, "t1_done");
    chk("t1_err", err, 0);
    chk("t1_status", status, 16'h0800);
    chk("t1_cmd", txq[0], {1'b0, 16'h08A2});
    chk("t1_w0", txq[1], {1'b1, 16'hA5A5});
    chk("t1_w1", txq[2], {1'b1, 16'h1234});
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);

    // RT->BC, three words
    txq.delete();
    start_txn(5'd1, 1'b1, 5'd3, 5'd3);
    wait_tx(1, "t2_txcount");
    repeat (2) @(negedge clk);
    send_rx(16'h0800, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send_rx(16'h1111, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send_rx(16'h2222, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send_rx(16'h3333, 1'b1, 1'b0);
    wait_done(50, "t2_done");
    chk("t2_cmd", txq[0], {1'b0, 16'h0C63});
    chk("t2_rx_count", rx_count, 3);
    chk("t2_err", err, 0);
    read_buf(5'd0, 16'h1111, "t2_buf0");
    read_buf(5'd1, 16'h2222, "t2_buf1");
    read_buf(5'd2, 16'h3333, "t2_buf2");

    // RT->BC, no response
    txq.delete();
    start_txn(5'd1, 1'b1, 5'd3, 5'd1);
    wait_tx(1, "t3_txcount");
    wait_done(3000, "t3_done");
    chk("t3_latency", done_cyc - fall_cyc, TIMEOUT + 1);
    chk("t3_err", err, 4'b0001);

    // Status from wrong address
    buf_write(5'd0, 16'h5555);
    txq.delete();
    start_txn(5'd1, 1'b0, 5'd1, 5'd1);
    wait_tx(2, "t4_txcount");
    repeat (2) @(negedge clk);
    send_rx(16'h1000, 1'b0, 1'b0);
    wait_done(50, "t4_done");
    chk("t4_err", err, 4'b0100);
    chk("t4_status", status, 16'h1000);

    // Parity error on second data word
    txq.delete();
    start_txn(5'd1, 1'b1, 5'd4, 5'd3);
    wait_tx(1, "t5_txcount");
    repeat (2) @(negedge clk);
    send_rx(16'h0800, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send_rx(16'hAAAA, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send_rx(16'hBBBB, 1'b1, 1'b1);
    wait_done(50, "t5_done");
    chk("t5_err", err, 4'b0010);
    chk("t5_rx_count", rx_count, 1);
    read_buf(5'd0, 16'hAAAA, "t5_buf0");
    read_buf(5'd1, 16'h2222, "t5_buf1_kept");

    // Broadcast BC->RT, with a start while busy
    buf_write(5'd0, 16'hCAFE);
    txq.delete();
    start_txn(5'd31, 1'b0, 5'd2, 5'd1);
    @(negedge clk);
    rt_addr = 5'd5; tr = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tx(2, "t6_txcount");
    wait_done(50, "t6_done");
    chk("t6_latency", done_cyc - fall_cyc, 1);
    chk("t6_err", err, 0);
    chk("t6_cmd", txq[0], {1'b0, 16'hF841});
    chk("t6_w0", txq[1], {1'b1, 16'hCAFE});
    repeat (10) @(negedge clk);
    chk("t6_ignored_busy", busy, 0);
    chk("t6_ignored_tx", txq.size(), 2);

    // Reset during RX_DATA
    txq.delete();
    start_txn(5'd1, 1'b1, 5'd6, 5'd4);
    wait_tx(1, "t7_txcount");
    repeat (2) @(negedge clk);
    send_rx(16'h0800, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send_rx(16'hDEAD, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t7_pre_count", rx_count, 1);
    chk("t7_pre_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_status", status, 0);
    chk("t7_err", err, 0);
    chk("t7_rx_count", rx_count, 0);
    chk("t7_tx_ready", tx_ready, 0);
    chk("t7_tx_data", tx_data, 0);
    chk("t7_tx_cd", tx_cd, 0);
    chk("t7_buf_rdata", buf_rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("t7_no_done", seen, 0);
    chk("t7_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
